countdown_timer: RTL and testbench

- Counts a loaded HH:MM:SS value down to 00:00:00 and pulses `done` on expiry.
- Decrement direction counterpart of the free-running up-counting time-of-day clock; uses the same 24-hour field encoding and widths.
- Internal clock prescaler; FSM controls load, start, pause, resume and expiry.
- Sits beside the time-of-day clock in the clock subsystem and feeds the alarm/annunciator logic.

---
 rtl/clock_pkg.sv | 46 ++++
 rtl/countdown_timer_if.sv | 27 ++
 rtl/tick_prescaler.sv | 36 +++
 rtl/countdown_timer.sv | 102 ++++++++++
 tb/tb_countdown_timer.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/clock_pkg.sv
// Shared clock-subsystem definitions: 24-hour field widths/limits, timer state
// encoding, and HH:MM:SS helpers reused by the time-of-day clock and alarm logic.
package clock_pkg;

  localparam int unsigned HOURS_W  = 5;
  localparam int unsigned MINSEC_W = 6;

  localparam logic [HOURS_W-1:0]  HOURS_MAX  = HOURS_W'(23);
  localparam logic [MINSEC_W-1:0] MINSEC_MAX = MINSEC_W'(59);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PAUSED,
    EXPIRED
  } cdt_state_t;

  typedef struct packed {
    logic [HOURS_W-1:0]  hours;
    logic [MINSEC_W-1:0] minutes;
    logic [MINSEC_W-1:0] seconds;
  } hms_t;

  function automatic logic hms_valid(input hms_t t);
    return (t.hours <= HOURS_MAX) && (t.minutes <= MINSEC_MAX) &&
           (t.seconds <= MINSEC_MAX);
  endfunction

  // One-second borrow chain; 00:00:00 is never decremented by the callers.
  function automatic hms_t hms_dec(input hms_t t);
    hms_t r;
    r = t;
    if (t.seconds != '0) begin
      r.seconds = t.seconds - MINSEC_W'(1);
    end else if (t.minutes != '0) begin
      r.seconds = MINSEC_MAX;
      r.minutes = t.minutes - MINSEC_W'(1);
    end else begin
      r.seconds = MINSEC_MAX;
      r.minutes = MINSEC_MAX;
      r.hours   = t.hours - HOURS_W'(1);
    end
    return r;
  endfunction

endpackage

// File: rtl/countdown_timer_if.sv
// Control/status bundle between the countdown timer and its host.
interface countdown_timer_if;
  import clock_pkg::*;

  logic                load;
  logic [HOURS_W-1:0]  load_hours;
  logic [MINSEC_W-1:0] load_minutes;
  logic [MINSEC_W-1:0] load_seconds;
  logic                start;
  logic                pause;
  logic [HOURS_W-1:0]  hours;
  logic [MINSEC_W-1:0] minutes;
  logic [MINSEC_W-1:0] seconds;
  logic                running;
  logic                done;
  logic                load_err;

  modport master (
    output load, load_hours, load_minutes, load_seconds, start, pause,
    input  hours, minutes, seconds, running, done, load_err
  );

  modport slave (
    input  load, load_hours, load_minutes, load_seconds, start, pause,
    output hours, minutes, seconds, running, done, load_err
  );
endinterface

// File: rtl/tick_prescaler.sv
// Divides clk by CLK_DIV while enabled; tick marks the wrap edge.
module tick_prescaler #(
  parameter int unsigned CLK_DIV = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int unsigned CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CNT_W'(1);
    end
  end

  assign tick = en && !clr && (cnt_q == LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/countdown_timer.sv
// HH:MM:SS countdown timer: load/start/pause/resume control, one-second
// prescaled borrow-chain decrement, registered done and load_err pulses.
module countdown_timer
  import clock_pkg::*;
#(
  parameter int unsigned CLK_DIV = 1
) (
  input  logic              clk,
  input  logic              rst,
  countdown_timer_if.slave  bus
);

  cdt_state_t state_q, state_d;
  hms_t       time_q, time_d;
  hms_t       load_val, dec_val;
  logic       done_q, done_d;
  logic       err_q, err_d;
  logic       running_q, running_d;
  logic       load_ok, time_zero, start_ok;
  logic       pre_en, pre_clr, tick;

  assign load_val  = {bus.load_hours, bus.load_minutes, bus.load_seconds};
  assign load_ok   = hms_valid(load_val);
  assign time_zero = (time_q == '0);
  assign dec_val   = hms_dec(time_q);

  // start only counts when neither higher-priority request is present
  assign start_ok = bus.start && !bus.load && !bus.pause && !time_zero;

  // Prescaler controls are kept out of the FSM process so tick does not
  // loop back through the same combinational block.
  assign pre_en  = (state_q == RUN) && !bus.load && !bus.pause;
  assign pre_clr = (bus.load && load_ok) || (start_ok && (state_q == IDLE));

  tick_prescaler #(
    .CLK_DIV (CLK_DIV)
  ) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .en   (pre_en),
    .clr  (pre_clr),
    .tick (tick)
  );

  always_comb begin
    state_d = state_q;
    time_d  = time_q;
    done_d  = 1'b0;
    err_d   = 1'b0;

    if (bus.load) begin
      if (load_ok) begin
        time_d  = load_val;
        state_d = IDLE;
      end else begin
        err_d = 1'b1;
      end
    end else if (bus.pause) begin
      if (state_q == RUN) begin
        state_d = PAUSED;
      end
    end else begin
      if (start_ok && ((state_q == IDLE) || (state_q == PAUSED))) begin
        state_d = RUN;
      end
      // tick is only ever asserted in RUN with no load/pause pending
      if (tick) begin
        time_d = dec_val;
        if (dec_val == '0) begin
          state_d = EXPIRED;
          done_d  = 1'b1;
        end
      end
    end

    running_d = (state_d == RUN);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      time_q    <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      time_q    <= time_d;
      done_q    <= done_d;
      err_q     <= err_d;
      running_q <= running_d;
    end
  end

  assign bus.hours    = time_q.hours;
  assign bus.minutes  = time_q.minutes;
  assign bus.seconds  = time_q.seconds;
  assign bus.running  = running_q;
  assign bus.done     = done_q;
  assign bus.load_err = err_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer: one instance at CLK_DIV=1, one at CLK_DIV=4.
module tb_countdown_timer;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  countdown_timer_if if1 ();
  countdown_timer_if if4 ();

  countdown_timer #(.CLK_DIV(1)) dut1 (.clk(clk), .rst(rst), .bus(if1));
  countdown_timer #(.CLK_DIV(4)) dut4 (.clk(clk), .rst(rst), .bus(if4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load1(input logic [4:0] h, input logic [5:0] m, input logic [5:0] s);
    if1.load = 1'b1; if1.load_hours = h; if1.load_minutes = m; if1.load_seconds = s;
    step();
    if1.load = 1'b0;
  endtask

  task automatic start1();
    if1.start = 1'b1;
    step();
    if1.start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #1;
    n_checks++;
    if ({if1.hours, if1.minutes, if1.seconds, if1.running, if1.done, if1.load_err} !== 20'd0) begin
      n_fail++; $display("FAIL reset_dut1: got %h want 0", {if1.hours, if1.minutes, if1.seconds, if1.running, if1.done, if1.load_err});
    end
    n_checks++;
    if ({if4.hours, if4.minutes, if4.seconds, if4.running, if4.done, if4.load_err} !== 20'd0) begin
      n_fail++; $display("FAIL reset_dut4: got %h want 0", {if4.hours, if4.minutes, if4.seconds, if4.running, if4.done, if4.load_err});
    end
    @(negedge clk);
    rst = 1'b1;
    step();
  endtask

  task automatic test_countdown();
    load1(5'd0, 6'd0, 6'd3);
    n_checks++;
    if (if1.seconds !== 6'd3 || if1.running !== 1'b0) begin
      n_fail++; $display("FAIL cd_load: got s=%0d run=%b want s=3 run=0", if1.seconds, if1.running);
    end
    start1();
    n_checks++;
    if (if1.seconds !== 6'd3 || if1.running !== 1'b1) begin
      n_fail++; $display("FAIL cd_edgeN: got s=%0d run=%b want s=3 run=1", if1.seconds, if1.running);
    end
    for (int i = 2; i >= 0; i--) begin
      step();
      n_checks++;
      if (if1.seconds !== 6'(i) || if1.done !== (i == 0) || if1.running !== (i != 0)) begin
        n_fail++; $display("FAIL cd_tick%0d: got s=%0d done=%b run=%b want s=%0d done=%b run=%b",
                           i, if1.seconds, if1.done, if1.running, i, (i == 0), (i != 0));
      end
    end
    step();
    n_checks++;
    if (if1.done !== 1'b0 || {if1.hours, if1.minutes, if1.seconds} !== 17'd0) begin
      n_fail++; $display("FAIL cd_done_fall: got done=%b t=%h want done=0 t=0", if1.done, {if1.hours, if1.minutes, if1.seconds});
    end
  endtask

  task automatic test_start_expired();
    start1();
    n_checks++;
    if (if1.running !== 1'b0 || if1.done !== 1'b0 || if1.seconds !== 6'd0) begin
      n_fail++; $display("FAIL start_expired: got run=%b done=%b s=%0d want 0 0 0", if1.running, if1.done, if1.seconds);
    end
  endtask

  task automatic test_borrow();
    load1(5'd1, 6'd0, 6'd0);
    start1();
    step();
    n_checks++;
    if ({if1.hours, if1.minutes, if1.seconds} !== {5'd0, 6'd59, 6'd59}) begin
      n_fail++; $display("FAIL borrow_hour: got %0d:%0d:%0d want 0:59:59", if1.hours, if1.minutes, if1.seconds);
    end
    load1(5'd0, 6'd1, 6'd0);
    n_checks++;
    if ({if1.hours, if1.minutes, if1.seconds} !== {5'd0, 6'd1, 6'd0} || if1.running !== 1'b0 || if1.done !== 1'b0) begin
      n_fail++; $display("FAIL load_in_run: got %0d:%0d:%0d run=%b done=%b want 0:1:0 run=0 done=0",
                         if1.hours, if1.minutes, if1.seconds, if1.running, if1.done);
    end
    start1();
    step();
    n_checks++;
    if ({if1.hours, if1.minutes, if1.seconds} !== {5'd0, 6'd0, 6'd59}) begin
      n_fail++; $display("FAIL borrow_min: got %0d:%0d:%0d want 0:0:59", if1.hours, if1.minutes, if1.seconds);
    end
    if1.pause = 1'b1;
    step();
    if1.pause = 1'b0;
    step();
    n_checks++;
    if (if1.seconds !== 6'd59 || if1.running !== 1'b0) begin
      n_fail++; $display("FAIL pause_dut1: got s=%0d run=%b want s=59 run=0", if1.seconds, if1.running);
    end
  endtask

  task automatic test_invalid_load();
    int bh[3] = '{24, 12, 12};
    int bm[3] = '{0, 60, 0};
    int bs[3] = '{0, 0, 60};
    load1(5'd5, 6'd6, 6'd7);
    n_checks++;
    if (if1.load_err !== 1'b0 || {if1.hours, if1.minutes, if1.seconds} !== {5'd5, 6'd6, 6'd7}) begin
      n_fail++; $display("FAIL good_load: got err=%b %0d:%0d:%0d want err=0 5:6:7", if1.load_err, if1.hours, if1.minutes, if1.seconds);
    end
    for (int i = 0; i < 3; i++) begin
      load1(5'(bh[i]), 6'(bm[i]), 6'(bs[i]));
      n_checks++;
      if (if1.load_err !== 1'b1 || {if1.hours, if1.minutes, if1.seconds} !== {5'd5, 6'd6, 6'd7}) begin
        n_fail++; $display("FAIL bad_load%0d: got err=%b %0d:%0d:%0d want err=1 5:6:7", i, if1.load_err, if1.hours, if1.minutes, if1.seconds);
      end
      step();
      n_checks++;
      if (if1.load_err !== 1'b0) begin
        n_fail++; $display("FAIL bad_load%0d_fall: got err=%b want 0", i, if1.load_err);
      end
    end
  endtask

  task automatic test_priority();
    if1.load = 1'b1; if1.start = 1'b1;
    if1.load_hours = 5'd0; if1.load_minutes = 6'd0; if1.load_seconds = 6'd5;
    step();
    if1.load = 1'b0; if1.start = 1'b0;
    step();
    n_checks++;
    if (if1.seconds !== 6'd5 || if1.minutes !== 6'd0 || if1.running !== 1'b0) begin
      n_fail++; $display("FAIL load_start: got s=%0d m=%0d run=%b want s=5 m=0 run=0", if1.seconds, if1.minutes, if1.running);
    end
    load1(5'd0, 6'd0, 6'd0);
    start1();
    step();
    n_checks++;
    if (if1.running !== 1'b0 || if1.done !== 1'b0 || if1.seconds !== 6'd0) begin
      n_fail++; $display("FAIL start_zero: got run=%b done=%b s=%0d want 0 0 0", if1.running, if1.done, if1.seconds);
    end
  endtask

  task automatic test_pause_resume();
    if4.load = 1'b1;
    if4.load_hours = 5'd0; if4.load_minutes = 6'd0; if4.load_seconds = 6'd10;
    step();
    if4.load = 1'b0;
    if4.start = 1'b1;
    step();
    if4.start = 1'b0;
    step();
    step();
    if4.pause = 1'b1;
    step();
    if4.pause = 1'b0;
    n_checks++;
    if (if4.running !== 1'b0 || if4.seconds !== 6'd10) begin
      n_fail++; $display("FAIL pr_paused: got run=%b s=%0d want run=0 s=10", if4.running, if4.seconds);
    end
    for (int i = 0; i < 6; i++) step();
    n_checks++;
    if (if4.seconds !== 6'd10 || if4.running !== 1'b0) begin
      n_fail++; $display("FAIL pr_hold: got s=%0d run=%b want s=10 run=0", if4.seconds, if4.running);
    end
    if4.start = 1'b1;
    step();
    if4.start = 1'b0;
    step();
    n_checks++;
    if (if4.seconds !== 6'd10 || if4.running !== 1'b1) begin
      n_fail++; $display("FAIL pr_resume1: got s=%0d run=%b want s=10 run=1", if4.seconds, if4.running);
    end
    step();
    n_checks++;
    if (if4.seconds !== 6'd9) begin
      n_fail++; $display("FAIL pr_resume2: got s=%0d want 9", if4.seconds);
    end
    step(); step(); step();
    if4.pause = 1'b1;
    step();
    if4.pause = 1'b0;
    n_checks++;
    if (if4.seconds !== 6'd9 || if4.running !== 1'b0) begin
      n_fail++; $display("FAIL pr_wrap_pause: got s=%0d run=%b want s=9 run=0", if4.seconds, if4.running);
    end
    if4.start = 1'b1;
    step();
    if4.start = 1'b0;
    step();
    n_checks++;
    if (if4.seconds !== 6'd8 || if4.running !== 1'b1) begin
      n_fail++; $display("FAIL pr_wrap_resume: got s=%0d run=%b want s=8 run=1", if4.seconds, if4.running);
    end
  endtask

  task automatic test_async_reset();
    load1(5'd0, 6'd10, 6'd0);
    start1();
    step();
    step();
    n_checks++;
    if ({if1.minutes, if1.seconds} !== {6'd9, 6'd58}) begin
      n_fail++; $display("FAIL ar_precount: got %0d:%0d want 9:58", if1.minutes, if1.seconds);
    end
    #2;
    rst = 1'b0;
    #1;
    n_checks++;
    if ({if1.hours, if1.minutes, if1.seconds, if1.running, if1.done, if1.load_err} !== 20'd0 ||
        {if4.hours, if4.minutes, if4.seconds, if4.running} !== 18'd0) begin
      n_fail++; $display("FAIL ar_immediate: got %h / %h want 0 / 0",
                         {if1.hours, if1.minutes, if1.seconds, if1.running, if1.done, if1.load_err},
                         {if4.hours, if4.minutes, if4.seconds, if4.running});
    end
    step();
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++;
      if ({if1.hours, if1.minutes, if1.seconds, if1.running, if1.done} !== 19'd0) begin
        n_fail++; $display("FAIL ar_after%0d: got %h want 0", i, {if1.hours, if1.minutes, if1.seconds, if1.running, if1.done});
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    {if1.load, if1.start, if1.pause} = 3'b000;
    {if1.load_hours, if1.load_minutes, if1.load_seconds} = '0;
    {if4.load, if4.start, if4.pause} = 3'b000;
    {if4.load_hours, if4.load_minutes, if4.load_seconds} = '0;

    test_reset();
    test_countdown();
    test_start_expired();
    test_borrow();
    test_invalid_load();
    test_priority();
    test_pause_resume();
    test_async_reset();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
